// File: rtl/iter_muldiv.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide, one bit
// per cycle, sharing a single 2*WIDTH work register. Result is {HI, LO}.
module iter_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [1:0]           op_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  input  logic                 annul_i,
  output logic                 busy_o,
  output logic                 stallreq_o,
  output logic                 ready_o,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 div_by_zero_o
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [1:0]         op_q;
  logic               neg_res_q, neg_rem_q;
  logic [WIDTH-1:0]   opnd_q;     // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] work_q;     // {acc, multiplier} or {rem, quot}

  logic               sgn, accept, is_dbz, last_iter;
  logic [WIDTH-1:0]   mag1, mag2;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH:0]   div_sh;
  logic [WIDTH+1:0]   div_diff;
  logic [WIDTH-1:0]   rem_fix, quot_fix;
  logic [2*WIDTH-1:0] fixed;

  assign sgn       = ~op_i[0];
  assign mag1      = (sgn & opdata1_i[WIDTH-1]) ? WIDTH'(-opdata1_i) : opdata1_i;
  assign mag2      = (sgn & opdata2_i[WIDTH-1]) ? WIDTH'(-opdata2_i) : opdata2_i;
  assign accept    = (state_q == IDLE) & start_i & ~annul_i;
  assign is_dbz    = op_i[1] & (opdata2_i == '0);
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

  // One multiply step: conditional add into the upper half, then shift right.
  assign mul_sum  = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, opnd_q} : '0);

  // One restoring-divide step on the left-shifted {rem, quot}.
  assign div_sh   = {work_q, 1'b0};
  assign div_diff = {1'b0, div_sh[2*WIDTH:WIDTH]} - {2'b00, opnd_q};

  assign quot_fix = neg_res_q ? WIDTH'(-work_q[WIDTH-1:0]) : work_q[WIDTH-1:0];
  assign rem_fix  = neg_rem_q ? WIDTH'(-work_q[2*WIDTH-1:WIDTH]) : work_q[2*WIDTH-1:WIDTH];
  assign fixed    = op_q[1] ? {rem_fix, quot_fix}
                            : (neg_res_q ? (2*WIDTH)'(-work_q) : work_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = is_dbz ? DONE : CALC;
      CALC: if (annul_i) state_d = IDLE;
            else if (last_iter) state_d = FIX;
      FIX:  state_d = annul_i ? IDLE : DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy_o     = (state_q != IDLE);
  assign ready_o    = (state_q == DONE) & ~annul_i;
  assign stallreq_o = (start_i & (state_q == IDLE)) | (state_q == CALC) | (state_q == FIX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q         <= '0;
      op_q          <= '0;
      neg_res_q     <= 1'b0;
      neg_rem_q     <= 1'b0;
      opnd_q        <= '0;
      work_q        <= '0;
      result_o      <= '0;
      div_by_zero_o <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          op_q      <= op_i;
          neg_res_q <= sgn & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
          neg_rem_q <= sgn & opdata1_i[WIDTH-1];
          cnt_q     <= '0;
          if (op_i[1]) begin
            opnd_q <= mag2;
            work_q <= {{WIDTH{1'b0}}, mag1};
          end else begin
            opnd_q <= mag1;
            work_q <= {{WIDTH{1'b0}}, mag2};
          end
          // Divide by zero skips straight to DONE with the result already formed.
          if (is_dbz) begin
            result_o      <= {opdata1_i, {WIDTH{1'b1}}};
            div_by_zero_o <= 1'b1;
          end
        end
        CALC: if (!annul_i) begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (op_q[1]) begin
            if (!div_diff[WIDTH+1])
              work_q <= {div_diff[WIDTH-1:0], div_sh[WIDTH-1:1], 1'b1};
            else
              work_q <= div_sh[2*WIDTH-1:0];
          end else begin
            work_q <= {mul_sum, work_q[WIDTH-1:1]};
          end
        end
        FIX: if (!annul_i) begin
          result_o      <= fixed;
          div_by_zero_o <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_muldiv.sv
// Directed bench for iter_muldiv (WIDTH = 32) with hand-computed expectations.
module tb_iter_muldiv;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           start_i;
  logic [1:0]     op_i;
  logic [W-1:0]   opdata1_i, opdata2_i;
  logic           annul_i;
  logic           busy_o, stallreq_o, ready_o, div_by_zero_o;
  logic [2*W-1:0] result_o;

  int compared   = 0;
  int mismatched = 0;

  iter_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i), .annul_i(annul_i),
    .busy_o(busy_o), .stallreq_o(stallreq_o), .ready_o(ready_o),
    .result_o(result_o), .div_by_zero_o(div_by_zero_o)
  );

  always #5 clk = ~clk;

  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

  task automatic check(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op (start sampled at the edge ending cycle 0), then watch cycles 1..
  // until two cycles past the first ready pulse. disturb pokes start/operands mid-CALC.
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit disturb, output int lat, output int pulses, output int busy_n);
    @(negedge clk);
    op_i = op; opdata1_i = a; opdata2_i = b; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    lat = -1; pulses = 0; busy_n = 0;
    for (int c = 1; c <= 60; c++) begin
      if (ready_o) begin
        pulses++;
        if (lat < 0) lat = c;
      end
      if (busy_o) busy_n++;
      if (lat >= 0 && c >= lat + 2) break;
      if (disturb && c == 5) begin
        start_i = 1'b1; op_i = MULTU; opdata1_i = 32'h1111_1111; opdata2_i = 32'h0000_0003;
      end
      if (disturb && c == 6) start_i = 1'b0;
      if (disturb && c == 12) begin opdata1_i = 32'hDEAD_BEEF; opdata2_i = 32'h0000_0001; end
      @(negedge clk);
    end
  endtask

  initial begin
    int lat, pulses, busy_n, extra;
    logic [2*W-1:0] held;

    rst = 1'b1; start_i = 1'b0; op_i = 2'b00; opdata1_i = '0; opdata2_i = '0; annul_i = 1'b0;
    #3;
    check("reset_busy",   64'(busy_o), 64'd0);
    check("reset_ready",  64'(ready_o), 64'd0);
    check("reset_result", result_o, 64'd0);
    check("reset_dbz",    64'(div_by_zero_o), 64'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Multiply
    run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat, pulses, busy_n);
    check("multu_result", result_o, 64'hFFFF_FFFE_0000_0001);
    check("multu_lat",    64'(lat), 64'd34);
    check("multu_pulses", 64'(pulses), 64'd1);
    check("multu_busy",   64'(busy_n), 64'd34);
    run_op(MULT, 32'hFFFF_FFFF, 32'h0000_0007, 1'b0, lat, pulses, busy_n);
    check("mult_neg",     result_o, 64'hFFFF_FFFF_FFFF_FFF9);

    // Signed / unsigned divide
    run_op(DIV, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, lat, pulses, busy_n);
    check("div_m7_2",     result_o, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(DIV, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, lat, pulses, busy_n);
    check("div_7_m2",     result_o, 64'h0000_0001_FFFF_FFFD);
    check("div_lat",      64'(lat), 64'd34);
    run_op(DIVU, 32'hFFFF_FFFF, 32'h0000_0010, 1'b0, lat, pulses, busy_n);
    check("divu_result",  result_o, 64'h0000_000F_0FFF_FFFF);

    // Edge cases
    run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat, pulses, busy_n);
    check("div_ovf",      result_o, 64'h0000_0000_8000_0000);
    check("div_ovf_dbz",  64'(div_by_zero_o), 64'd0);
    run_op(DIVU, 32'h0000_1234, 32'h0000_0000, 1'b0, lat, pulses, busy_n);
    check("dbz_lat",      64'(lat), 64'd1);
    check("dbz_result",   result_o, 64'h0000_1234_FFFF_FFFF);
    check("dbz_flag",     64'(div_by_zero_o), 64'd1);
    check("dbz_pulses",   64'(pulses), 64'd1);

    // Annul mid-CALC, then restart
    held = result_o;
    @(negedge clk);
    op_i = DIV; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    for (int c = 1; c < 10; c++) @(negedge clk);
    annul_i = 1'b1;
    @(negedge clk);
    annul_i = 1'b0;
    check("annul_idle",   64'(busy_o), 64'd0);
    extra = 0;
    for (int c = 0; c < 40; c++) begin
      if (ready_o) extra++;
      @(negedge clk);
    end
    check("annul_no_ready", 64'(extra), 64'd0);
    check("annul_result",   result_o, held);
    run_op(MULTU, 32'd3, 32'd5, 1'b0, lat, pulses, busy_n);
    check("restart_result", result_o, 64'd15);
    check("restart_dbz",    64'(div_by_zero_o), 64'd0);

    // Ignored start and operand changes during CALC
    run_op(DIVU, 32'd100, 32'd7, 1'b1, lat, pulses, busy_n);
    check("stable_result", result_o, {32'd2, 32'd14});
    check("stable_lat",    64'(lat), 64'd34);
    check("stable_pulses", 64'(pulses), 64'd1);

    // Asynchronous reset mid-CALC
    @(negedge clk);
    op_i = MULTU; opdata1_i = 32'd9; opdata2_i = 32'd9; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    for (int c = 1; c < 5; c++) @(negedge clk);
    check("pre_rst_busy", 64'(busy_o), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_busy",     64'(busy_o), 64'd0);
    check("rst_result",   result_o, 64'd0);
    check("rst_stall0",   64'(stallreq_o), 64'd0);
    start_i = 1'b1;
    #1;
    check("rst_stall1",   64'(stallreq_o), 64'd1);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run_op(MULT, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 1'b0, lat, pulses, busy_n);
    check("post_rst_result", result_o, 64'd15);
    check("post_rst_lat",    64'(lat), 64'd34);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/iter_muldiv.md
Name: iter_muldiv

Overview:
- Parametrised iterative multiply/divide unit for the EX stage. Replaces the separate fixed-width mul and div instances with one shared datapath.
- Operations: signed/unsigned multiply and signed/unsigned divide, one bit per cycle.
- Uses a start/ready handshake, an annul input and a stall request that EX forwards to the stall controller.
- The 2*WIDTH result feeds the HI/LO write path: HI = upper half, LO = lower half.

Parameters:
- WIDTH, 32: operand width in bits; result width is 2*WIDTH; must be >= 4.
- CNT_W, $clog2(WIDTH)+1: iteration counter width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous active-high reset.
- start_i  in  1  request an operation; sampled only in IDLE.
- op_i  in  2  00 mult (signed), 01 multu, 10 div (signed), 11 divu.
- opdata1_i  in  WIDTH  multiplicand / dividend.
- opdata2_i  in  WIDTH  multiplier / divisor.
- annul_i  in  1  abort the current operation (flush).
- busy_o  out  1  an operation is in progress.
- stallreq_o  out  1  request pipeline stall = (start_i & IDLE) | CALC | FIX.
- ready_o  out  1  one-cycle pulse: result_o is valid.
- result_o  out  2*WIDTH  mult: product; div: {remainder, quotient}.
- div_by_zero_o  out  1  valid with ready_o; set when a divide had divisor 0.

Behaviour:
- Reset, asynchronous and immediate, including mid-operation:
  - state = IDLE.
  - busy_o = 0, ready_o = 0, result_o = 0, div_by_zero_o = 0, counter = 0.
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE:
  - start_i = 1 latches op_i and the operand magnitudes: absolute value when signed, raw when unsigned.
  - It also latches the sign flags neg_res = s1^s2 and neg_rem = s1, where s1/s2 are the operand MSBs (signed ops only) and both flags are 0 for unsigned ops.
  - Divide with opdata2_i == 0 goes to DONE.
  - Any other op clears the counter and goes to CALC.
- CALC: runs exactly WIDTH cycles; the counter increments each cycle; the last iteration goes to FIX.
  - Multiply is shift-add: if multiplier LSB = 1, add the multiplicand into the upper accumulator; then shift the {acc, multiplier} register right by 1.
  - Divide is restoring: shift {rem, quot} left by 1; trial = rem - divisor (WIDTH+1 bits); if non-negative, rem = trial and quot LSB = 1.
- FIX: one cycle.
  - Multiply: result = neg_res ? two's-complement negation of the 2*WIDTH product : product.
  - Divide: quot is negated if neg_res; rem is negated if neg_rem.
  - Goes to DONE.
- DONE: one cycle.
  - ready_o = 1 and result_o is updated this cycle.
  - div_by_zero_o is set for the divide-by-zero path, otherwise cleared.
  - Goes to IDLE.
- Latency: start_i accepted at cycle 0 gives ready_o high in cycle WIDTH+2 (34 cycles for WIDTH = 32). Divide-by-zero: ready_o in cycle 1.
- Divide-by-zero result: quotient = all ones, remainder = opdata1_i unmodified.
- Signed overflow: (-2^(WIDTH-1)) / (-1) gives quotient = 2^(WIDTH-1) as a bit pattern (0x80000000) and remainder 0. No exception is raised.
- Most-negative operands are handled as unsigned magnitude 2^(WIDTH-1); no widening is needed for the magnitude registers.
- busy_o = 1 in CALC, FIX and DONE.
- start_i is ignored whenever the state is not IDLE; there is no queueing.
- result_o holds its value after DONE until the next DONE. ready_o is 0 outside DONE.
- annul_i = 1:
  - In CALC or FIX: go to IDLE at the next edge; no ready_o; result_o is unchanged.
  - In DONE: ready_o is suppressed for that cycle and the state goes to IDLE.
  - In IDLE: annul_i overrides start_i, so the request is not accepted.
- Operands are sampled only at acceptance; changes to opdata*_i during CALC have no effect.
- Back-to-back operation: start_i may be accepted in the IDLE cycle immediately after DONE.

Test Plan (WIDTH = 32):
1. Multiply: multu 0xFFFFFFFF x 0xFFFFFFFF -> result_o = 0xFFFFFFFE_00000001, ready_o pulses exactly at cycle 34, busy_o = 1 in cycles 1-34. mult 0xFFFFFFFF (-1) x 0x00000007 -> 0xFFFFFFFF_FFFFFFF9.
2. Signed divide: div -7 / 2 -> quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1). div 7 / -2 -> quotient 0xFFFFFFFD, remainder 0x00000001. divu 0xFFFFFFFF / 0x10 -> quotient 0x0FFFFFFF, remainder 0xF.
3. Edge cases: div 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0, div_by_zero_o = 0. divu 0x1234 / 0 -> ready_o at cycle 1, result_o = {0x00001234, 0xFFFFFFFF}, div_by_zero_o = 1.
4. Annul and restart: start div, assert annul_i at cycle 10 -> state IDLE at cycle 11, no ready_o, result_o keeps its previous value. A new multu 3 x 5 then completes with 15.
5. Ignored start and operand stability: assert start_i with new operands during CALC; toggle opdata*_i mid-CALC -> the original operation's result is unaffected and only one ready_o pulse occurs.
6. Async reset: assert rst mid-CALC (cycle 5) without a clock edge -> outputs reset immediately: busy_o = 0, result_o = 0, stallreq_o follows start_i only. The next operation completes normally with correct latency.
